// File: rtl/tinyalu_cmd_issuer.sv
// tinyalu_cmd_issuer: buffers ALU commands in a small FIFO and sequences them
// onto the TinyALU start/done pins. Each result comes back as a one-cycle
// response strobe. A timer guards against an ALU that never raises done.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is registered and reflects !full after that
// edge, so a pop in the same cycle never frees a slot early. rsp_valid is a
// single-cycle strobe with no backpressure.
module tinyalu_cmd_issuer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  output logic        alu_reset_n,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_error,
  output logic        busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_RST = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    ARST = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_d;

  // FIFO entry layout: {op, a, b}
  logic [18:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          push, pop;
  logic [18:0]   head;
  logic [2:0]    head_op;

  // Next values of the registered outputs
  logic [7:0]    alu_a_d, alu_b_d;
  logic [2:0]    alu_op_d, rsp_op_d;
  logic          start_d, rstn_d, rsp_valid_d, rsp_error_d;
  logic [15:0]   rsp_result_d;

  assign push    = cmd_valid && cmd_ready;
  assign pop     = (state == IDLE) && (count != '0);
  assign head    = fifo_mem[rd_ptr];
  assign head_op = head[18:16];
  assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  // FIFO storage write; contents are don't-care once the pointers reset
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
  end

  // State register plus every registered output and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cmd_ready   <= 1'b0;
      alu_A       <= 8'h00;
      alu_B       <= 8'h00;
      alu_op      <= 3'b000;
      alu_start   <= 1'b0;
      alu_reset_n <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= 16'h0000;
      rsp_op      <= 3'b000;
      rsp_error   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      timer       <= timer_d;
      count       <= count_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cmd_ready   <= (count_next != FULL_COUNT);
      alu_A       <= alu_a_d;
      alu_B       <= alu_b_d;
      alu_op      <= alu_op_d;
      alu_start   <= start_d;
      alu_reset_n <= rstn_d;
      rsp_valid   <= rsp_valid_d;
      rsp_result  <= rsp_result_d;
      rsp_op      <= rsp_op_d;
      rsp_error   <= rsp_error_d;
      busy        <= (state_next != IDLE) || (count_next != '0);
    end
  end

  // Next-state: dispatch on the popped opcode, done beats timeout in RUN
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pop) begin
          case (head_op)
            OP_ADD, OP_AND, OP_XOR, OP_MUL: state_next = RUN;
            OP_NOP:                         state_next = GAP;
            OP_RST:                         state_next = ARST;
            default:                        state_next = IDLE;
          endcase
        end
      end
      RUN: begin
        if (alu_done)                 state_next = GAP;
        else if (timer == TIMER_LAST) state_next = ARST;
      end
      GAP:     state_next = IDLE;
      ARST:    state_next = GAP;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: ALU pins hold between commands, rsp_valid is a strobe
  always_comb begin
    alu_a_d      = alu_A;
    alu_b_d      = alu_B;
    alu_op_d     = alu_op;
    start_d      = alu_start;
    rstn_d       = 1'b1;
    rsp_valid_d  = 1'b0;
    rsp_result_d = rsp_result;
    rsp_op_d     = rsp_op;
    rsp_error_d  = rsp_error;
    timer_d      = timer;
    case (state)
      IDLE: begin
        if (pop) begin
          alu_a_d  = head[15:8];
          alu_b_d  = head[7:0];
          alu_op_d = head_op;
          case (head_op)
            OP_ADD, OP_AND, OP_XOR, OP_MUL: begin
              start_d = 1'b1;
              timer_d = '0;
            end
            OP_NOP: start_d = 1'b1;
            OP_RST: rstn_d  = 1'b0;
            default: begin
              rsp_valid_d  = 1'b1;
              rsp_error_d  = 1'b1;
              rsp_result_d = 16'h0000;
              rsp_op_d     = head_op;
            end
          endcase
        end
      end
      RUN: begin
        timer_d = timer + TW'(1);
        if (alu_done) begin
          start_d      = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_result_d = alu_result;
          rsp_op_d     = alu_op;
          rsp_error_d  = 1'b0;
        end else if (timer == TIMER_LAST) begin
          start_d      = 1'b0;
          rstn_d       = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_result_d = 16'h0000;
          rsp_op_d     = alu_op;
          rsp_error_d  = 1'b1;
        end
      end
      GAP:     start_d = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tinyalu_cmd_issuer.sv
// Bench for tinyalu_cmd_issuer: an emulated TinyALU with per-command done
// latency, a reference model of expected responses and issued commands,
// and one task per scenario.
module tb_tinyalu_cmd_issuer;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 31;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_a = 8'h00, cmd_b = 8'h00;
  logic [2:0]  cmd_op = 3'b000;
  logic [7:0]  alu_A, alu_B;
  logic [2:0]  alu_op;
  logic        alu_start, alu_reset_n;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = 16'h0000;
  logic        rsp_valid;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_error;
  logic        busy;

  tinyalu_cmd_issuer #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_start(alu_start), .alu_reset_n(alu_reset_n),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_op(rsp_op),
    .rsp_error(rsp_error), .busy(busy)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_at_edge = 1'b1;
  always @(posedge clk) begin
    cyc = cyc + 1;
    rst_at_edge = reset;
  end

  // ---------------- reference model state ----------------
  // expected response: {error, op, result}
  logic [19:0] exp_q[$];
  // expected start-raising command: {lat[7:0], op, a, b}
  logic [26:0] iss_q[$];
  int n_vec = 0, n_err = 0;
  int n_starts = 0, n_rsp = 0, n_rst_pulses = 0, exp_rst_pulses = 0;
  logic [15:0] last_rsp_result = 16'h0000;

  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b001:  return 16'(a) + 16'(b);
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic bit is_alu_op(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b010) || (op == 3'b011) || (op == 3'b100);
  endfunction

  // A command accepted by the DUT: record what must happen to it.
  task automatic model_accept(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input int lat);
    bit tmo;
    tmo = (lat == 0) || (lat > TIMEOUT);
    if (is_alu_op(op)) begin
      iss_q.push_back({8'(lat), op, a, b});
      exp_q.push_back({tmo, op, tmo ? 16'h0000 : alu_fn(op, a, b)});
      if (tmo) exp_rst_pulses++;
    end else if (op == 3'b000) begin
      iss_q.push_back({8'(lat), op, a, b});
    end else if (op == 3'b111) begin
      exp_rst_pulses++;
    end else begin
      exp_q.push_back({1'b1, op, 16'h0000});
    end
  endtask

  // ---------------- ALU emulation + scoreboard ----------------
  logic        prev_start = 1'b0, prev_rstn = 1'b1;
  int          rise_cyc = 0, cur_lat = 0, cur_dur = 0, alu_cnt = 0;
  logic [26:0] iss_e;
  logic [19:0] rsp_e;

  always @(negedge clk) begin
    if (rst_at_edge) begin
      alu_done = 1'b0;
      alu_cnt  = 0;
      prev_rstn = 1'b1;
    end else begin
      if (alu_start && !prev_start) begin
        n_starts++;
        rise_cyc = cyc;
        alu_cnt  = 0;
        n_vec++;
        if (iss_q.size() == 0) begin
          n_err++;
          $display("FAIL start_unexpected: alu_start rose with op %b, required no start", alu_op);
          cur_lat = 0;
          cur_dur = 1;
        end else begin
          iss_e = iss_q.pop_front();
          if ({alu_op, alu_A, alu_B} !== iss_e[18:0]) begin
            n_err++;
            $display("FAIL issue_operands: op/A/B=%b/%h/%h, required %b/%h/%h",
                     alu_op, alu_A, alu_B, iss_e[18:16], iss_e[15:8], iss_e[7:0]);
          end
          cur_lat = int'(iss_e[26:19]);
          if (iss_e[18:16] == 3'b000) cur_dur = 1;
          else if (cur_lat == 0 || cur_lat > TIMEOUT) cur_dur = TIMEOUT;
          else cur_dur = cur_lat;
        end
      end
      if (!alu_start && prev_start) begin
        n_vec++;
        if (cyc - rise_cyc != cur_dur) begin
          n_err++;
          $display("FAIL start_width: alu_start high %0d cycles, required %0d", cyc - rise_cyc, cur_dur);
        end
      end
      if (!alu_reset_n) begin
        n_vec++;
        if (prev_rstn) n_rst_pulses++;
        else begin
          n_err++;
          $display("FAIL rstn_width: alu_reset_n low for 2+ cycles, required 1");
        end
      end
      if (rsp_valid) begin
        n_rsp++;
        last_rsp_result = rsp_result;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rsp_unexpected: got err/op/result=%b/%b/%h, required no response",
                   rsp_error, rsp_op, rsp_result);
        end else begin
          rsp_e = exp_q.pop_front();
          if ({rsp_error, rsp_op, rsp_result} !== rsp_e) begin
            n_err++;
            $display("FAIL rsp_fields: err/op/result=%b/%b/%h, required %b/%b/%h",
                     rsp_error, rsp_op, rsp_result, rsp_e[19], rsp_e[18:16], rsp_e[15:0]);
          end
          if (is_alu_op(rsp_e[18:16])) begin
            n_vec++;
            if (!(prev_start && !alu_start)) begin
              n_err++;
              $display("FAIL rsp_timing: start prev/now=%b/%b at response, required 1/0", prev_start, alu_start);
            end
            if (rsp_e[19]) begin
              n_vec++;
              if (alu_reset_n !== 1'b0) begin
                n_err++;
                $display("FAIL timeout_rstn: alu_reset_n=%b with timeout response, required 0", alu_reset_n);
              end
            end
          end
        end
      end
      // ALU: raise done for one cycle once start has been high cur_lat cycles
      if (alu_start) begin
        alu_cnt++;
        alu_done   = (cur_lat != 0) && (alu_cnt == cur_lat);
        alu_result = alu_done ? alu_fn(alu_op, alu_A, alu_B) : 16'($urandom);
      end else begin
        alu_done = 1'b0;
        alu_cnt  = 0;
      end
      prev_rstn = alu_reset_n;
    end
    prev_start = alu_start;
  end

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    while (cmd_ready !== 1'b1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      n_vec++;
      n_err++;
      $display("FAIL push_wait: cmd_ready=%b after 500 cycles, required 1", cmd_ready);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_accept(a, b, op, lat);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || exp_q.size() != 0) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (guard >= 3000) begin
      n_err++;
      $display("FAIL %s_idle: busy=%b pending_rsp=%0d after 3000 cycles, required 0/0", tag, busy, exp_q.size());
    end
    n_vec++;
    if (iss_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_issued: %0d commands never started, required 0", tag, iss_q.size());
    end
    n_vec++;
    if (n_rst_pulses != exp_rst_pulses) begin
      n_err++;
      $display("FAIL %s_rst_pulses: %0d alu_reset_n pulses, required %0d", tag, n_rst_pulses, exp_rst_pulses);
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_vec++;
    if ({cmd_ready, alu_start, alu_reset_n, rsp_valid, rsp_error, busy} !== 6'b000000) begin
      n_err++;
      $display("FAIL %s_ctrl: ready/start/rstn/rspv/err/busy=%b%b%b%b%b%b, required 000000",
               tag, cmd_ready, alu_start, alu_reset_n, rsp_valid, rsp_error, busy);
    end
    n_vec++;
    if ({alu_A, alu_B, alu_op, rsp_op, rsp_result} !== 38'h0) begin
      n_err++;
      $display("FAIL %s_data: A/B/op/rsp_op/rsp_result=%h/%h/%b/%b/%h, required all 0",
               tag, alu_A, alu_B, alu_op, rsp_op, rsp_result);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({cmd_ready, alu_reset_n, busy} !== 3'b110) begin
      n_err++;
      $display("FAIL reset_release: ready/rstn/busy=%b%b%b, required 110", cmd_ready, alu_reset_n, busy);
    end
  endtask

  task automatic test_add();
    int s;
    s = n_rsp;
    push_cmd(8'h12, 8'h34, 3'b001, 3);
    wait_idle("add");
    n_vec++;
    if (n_rsp - s != 1 || last_rsp_result !== 16'h0046) begin
      n_err++;
      $display("FAIL add_result: %0d responses last=%h, required 1 and 0046", n_rsp - s, last_rsp_result);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    s = n_starts;
    for (int i = 0; i < 5; i++) push_cmd(8'($urandom), 8'($urandom), 3'b100, 12);
    @(negedge clk);
    // one command is executing, the rest sit in the FIFO
    n_vec++;
    if (cmd_ready !== ((5 - (n_starts - s)) < FIFO_DEPTH)) begin
      n_err++;
      $display("FAIL b2b_full: cmd_ready=%b with %0d queued, required %b",
               cmd_ready, 5 - (n_starts - s), (5 - (n_starts - s)) < FIFO_DEPTH);
    end
    push_cmd(8'($urandom), 8'($urandom), 3'b100, 2);
    wait_idle("b2b");
  endtask

  task automatic test_noop_rst();
    int s;
    s = n_rsp;
    push_cmd(8'h01, 8'h02, 3'b000, 1);
    push_cmd(8'h03, 8'h04, 3'b111, 0);
    wait_idle("noop_rst");
    n_vec++;
    if (n_rsp != s) begin
      n_err++;
      $display("FAIL noop_rst_rsp: %0d responses, required 0", n_rsp - s);
    end
  endtask

  task automatic test_illegal();
    int s;
    s = n_starts;
    push_cmd(8'hAA, 8'h55, 3'b101, 0);
    push_cmd(8'h0F, 8'hF0, 3'b110, 0);
    wait_idle("illegal");
    n_vec++;
    if (n_starts != s) begin
      n_err++;
      $display("FAIL illegal_start: %0d starts, required 0", n_starts - s);
    end
  endtask

  task automatic test_timeout();
    push_cmd(8'h5A, 8'hC3, 3'b011, 0);
    push_cmd(8'h10, 8'h20, 3'b001, 2);
    wait_idle("timeout");
    // done on the expiry edge wins; one cycle later it loses
    push_cmd(8'h7F, 8'h01, 3'b001, TIMEOUT);
    push_cmd(8'h09, 8'h09, 3'b100, TIMEOUT + 1);
    push_cmd(8'hF0, 8'h3C, 3'b010, 1);
    wait_idle("boundary");
  endtask

  task automatic test_random();
    int r, lat;
    logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      if (r == 9) lat = $urandom_range(TIMEOUT - 1, TIMEOUT + 2);
      else lat = r;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      push_cmd(8'($urandom), 8'($urandom), op, lat);
    end
    wait_idle("random");
  endtask

  task automatic test_reset_mid();
    int guard, s;
    for (int i = 0; i < 3; i++) push_cmd(8'($urandom), 8'($urandom), 3'b100, 0);
    guard = 0;
    while (alu_start !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (guard >= 50) begin
      n_err++;
      $display("FAIL midrst_start: alu_start=%b after 50 cycles, required 1", alu_start);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    // reset discards all three hung commands before any of them timed out
    exp_q.delete();
    iss_q.delete();
    exp_rst_pulses -= 3;
    reset = 1'b0;
    s = n_starts;
    repeat (40) @(negedge clk);
    n_vec++;
    if (n_starts != s || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_after: starts=%0d busy=%b ready=%b, required 0/0/1", n_starts - s, busy, cmd_ready);
    end
    wait_idle("midrst");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_noop_rst();
    test_illegal();
    test_timeout();
    test_random();
    test_reset_mid();
    test_add();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
